// File: rtl/bf_prog_loader_if.sv
// ---------------------------------------------------------------------------
// bf_prog_loader_if
// Source byte stream feeding the Boolfuck program loader.
//   in_valid  source -> loader   byte on in_data is valid
//   in_ready  loader -> source   loader accepts the byte this cycle
//   in_data   source -> loader   ASCII source byte
//   in_last   source -> loader   marks the final byte of the source
// A byte moves when in_valid and in_ready are both high on a rising edge.
// ---------------------------------------------------------------------------
interface bf_prog_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/bf_prog_loader.sv
// ---------------------------------------------------------------------------
// bf_prog_loader
// Program-load sequencer for the Boolfuck core. Translates an ASCII source
// stream into 3-bit opcodes, writes them into program memory, appends a
// halt terminator (000) and checks bracket balance and nesting depth.
// A one-cycle run pulse announces a valid program.
//
// Parameters
//   C  program address width (program memory depth 2**C)
//   S  loop-stack index width; legal nesting depth is 1 .. 2**S-1
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        begin a load; honoured only in IDLE, DONE or ERR
//   src          source byte stream (valid/ready handshake)
//   prg_we       program memory write strobe
//   prg_addr     program memory write address
//   prg_wdata    opcode being written
//   prg_len      opcodes written so far, excluding the terminator
//   run          one-cycle pulse: program loaded and valid
//   busy         high while loading, draining or terminating
//   done, err    load finished successfully / with an error
//   err_code     00 unclosed '[', 01 ']' underflow, 10 too deep, 11 too long
// ---------------------------------------------------------------------------
module bf_prog_loader #(
    parameter int C = 8,
    parameter int S = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    bf_prog_loader_if.slave   src,
    output logic              prg_we,
    output logic [C-1:0]      prg_addr,
    output logic [2:0]        prg_wdata,
    output logic [C-1:0]      prg_len,
    output logic              run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        TERM,
        DONE,
        ERR
    } state_t;

    localparam logic [C-1:0] ADDR_MAX  = '1;
    localparam logic [S-1:0] DEPTH_MAX = '1;

    localparam logic [2:0] OP_OPEN  = 3'b110;
    localparam logic [2:0] OP_CLOSE = 3'b111;

    state_t       state;
    logic [C-1:0] addr_cnt;
    logic [S-1:0] depth;

    logic         is_op;
    logic [2:0]   opcode;
    logic         handshake;

    // Ready is a pure function of state so the source sees it without
    // waiting on anything it drives itself.
    assign src.in_ready = (state == LOAD) || (state == DRAIN);
    assign handshake    = src.in_valid && src.in_ready;

    // Character-to-opcode translation; anything unlisted is a comment.
    always_comb begin
        is_op  = 1'b1;
        opcode = 3'b000;
        case (src.in_data)
            8'h2B:   opcode = 3'b001;  // '+'
            8'h3C:   opcode = 3'b010;  // '<'
            8'h3E:   opcode = 3'b011;  // '>'
            8'h3B:   opcode = 3'b100;  // ';'
            8'h2C:   opcode = 3'b101;  // ','
            8'h5B:   opcode = 3'b110;  // '['
            8'h5D:   opcode = 3'b111;  // ']'
            default: is_op  = 1'b0;
        endcase
    end

    // Load sequencer. All outputs are registered here; prg_we and run are
    // single-cycle strobes that default low every cycle. Error checks are
    // made before any count update, so the address counter never wraps and
    // the top address is always left free for the terminator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            depth     <= '0;
            prg_we    <= 1'b0;
            prg_addr  <= '0;
            prg_wdata <= 3'b000;
            prg_len   <= '0;
            run       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            prg_we <= 1'b0;
            run    <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LOAD;
                        addr_cnt <= '0;
                        depth    <= '0;
                        prg_len  <= '0;
                        err_code <= 2'b00;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end

                LOAD: begin
                    if (handshake) begin
                        if (is_op && (addr_cnt == ADDR_MAX ||
                                      (opcode == OP_OPEN && depth == DEPTH_MAX) ||
                                      (opcode == OP_CLOSE && depth == '0))) begin
                            // Only one error can occur per load: the next
                            // state never returns to LOAD.
                            if (addr_cnt == ADDR_MAX) begin
                                err_code <= 2'b11;
                            end else if (opcode == OP_OPEN) begin
                                err_code <= 2'b10;
                            end else begin
                                err_code <= 2'b01;
                            end
                            if (src.in_last) begin
                                state <= ERR;
                                busy  <= 1'b0;
                                err   <= 1'b1;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            if (is_op) begin
                                prg_we    <= 1'b1;
                                prg_addr  <= addr_cnt;
                                prg_wdata <= opcode;
                                addr_cnt  <= addr_cnt + 1'b1;
                                prg_len   <= addr_cnt + 1'b1;
                                if (opcode == OP_OPEN) begin
                                    depth <= depth + 1'b1;
                                end else if (opcode == OP_CLOSE) begin
                                    depth <= depth - 1'b1;
                                end
                            end
                            if (src.in_last) begin
                                state <= TERM;
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (handshake && src.in_last) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end

                TERM: begin
                    // The terminator always lands just after the last opcode,
                    // even when the brackets turn out to be unbalanced.
                    prg_we    <= 1'b1;
                    prg_addr  <= addr_cnt;
                    prg_wdata <= 3'b000;
                    busy      <= 1'b0;
                    if (depth == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        run   <= 1'b1;
                    end else begin
                        state    <= ERR;
                        err      <= 1'b1;
                        err_code <= 2'b00;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_bf_prog_loader
// Self-checking bench for bf_prog_loader. Three instances share one source
// stream: dut0 (C=8,S=6), dut1 (C=8,S=2) and dut2 (C=3,S=6), so the
// depth-limit and length-limit cases run alongside the default build.
// Expected writes are predicted per instance when a stream is driven and
// popped by a monitor as each prg_we strobe appears.
// ---------------------------------------------------------------------------
module tb_bf_prog_loader;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic       last  = 1'b0;
    logic [7:0] data  = 8'h00;

    always #5 clk = ~clk;

    bf_prog_loader_if src0 ();
    bf_prog_loader_if src1 ();
    bf_prog_loader_if src2 ();

    assign src0.in_valid = valid;
    assign src0.in_data  = data;
    assign src0.in_last  = last;
    assign src1.in_valid = valid;
    assign src1.in_data  = data;
    assign src1.in_last  = last;
    assign src2.in_valid = valid;
    assign src2.in_data  = data;
    assign src2.in_last  = last;

    logic       we [3];
    logic [7:0] addr [3];
    logic [2:0] wd [3];
    logic [7:0] len [3];
    logic       rn [3];
    logic       bs [3];
    logic       dn [3];
    logic       er [3];
    logic [1:0] ec [3];
    logic [2:0] addr_c3;
    logic [2:0] len_c3;

    assign addr[2] = {5'd0, addr_c3};
    assign len[2]  = {5'd0, len_c3};

    bf_prog_loader #(.C(8), .S(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src0),
        .prg_we(we[0]), .prg_addr(addr[0]), .prg_wdata(wd[0]), .prg_len(len[0]),
        .run(rn[0]), .busy(bs[0]), .done(dn[0]), .err(er[0]), .err_code(ec[0])
    );

    bf_prog_loader #(.C(8), .S(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src1),
        .prg_we(we[1]), .prg_addr(addr[1]), .prg_wdata(wd[1]), .prg_len(len[1]),
        .run(rn[1]), .busy(bs[1]), .done(dn[1]), .err(er[1]), .err_code(ec[1])
    );

    bf_prog_loader #(.C(3), .S(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .src(src2),
        .prg_we(we[2]), .prg_addr(addr_c3), .prg_wdata(wd[2]), .prg_len(len_c3),
        .run(rn[2]), .busy(bs[2]), .done(dn[2]), .err(er[2]), .err_code(ec[2])
    );

    int         errors = 0;
    int         checks = 0;
    int         run_cnt [3];
    int         gap_nrdy = 0;
    logic [10:0] exp_q [3][$];
    logic [10:0] mon_exp;

    // Write scoreboard: every strobe must match the next predicted
    // {address, opcode}; a strobe with nothing predicted is a failure.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (we[k] === 1'b1) begin
                checks++;
                if (exp_q[k].size() == 0) begin
                    errors++;
                    $display("[TB] FAIL write_unexpected dut%0d: got addr=%0d op=%b, required no write",
                             k, addr[k], wd[k]);
                end else begin
                    mon_exp = exp_q[k].pop_front();
                    if ({addr[k], wd[k]} !== mon_exp) begin
                        errors++;
                        $display("[TB] FAIL write dut%0d: got addr=%0d op=%b, required addr=%0d op=%b",
                                 k, addr[k], wd[k], mon_exp[10:3], mon_exp[2:0]);
                    end
                end
            end
            if (rn[k] === 1'b1) run_cnt[k]++;
        end
    end

    function automatic int op_of(input byte c);
        case (c)
            8'h2B:   return 1;
            8'h3C:   return 2;
            8'h3E:   return 3;
            8'h3B:   return 4;
            8'h2C:   return 5;
            8'h5B:   return 6;
            8'h5D:   return 7;
            default: return -1;
        endcase
    endfunction

    // Reference model of the writes one instance should make for a whole
    // stream; the terminator is expected only when no byte error occurred.
    function automatic void predict(input int k, input string s);
        int amax;
        int dmax;
        int cnt;
        int depth;
        int op;
        bit bad;
        amax  = (k == 2) ? 7 : 255;
        dmax  = (k == 1) ? 3 : 63;
        cnt   = 0;
        depth = 0;
        bad   = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            op = op_of(s[i]);
            if (!bad && op > 0) begin
                if (cnt == amax || (op == 6 && depth == dmax) || (op == 7 && depth == 0)) begin
                    bad = 1'b1;
                end else begin
                    exp_q[k].push_back({cnt[7:0], op[2:0]});
                    cnt++;
                    if (op == 6) depth++;
                    if (op == 7) depth--;
                end
            end
        end
        if (!bad) exp_q[k].push_back({cnt[7:0], 3'b000});
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input byte c, input bit is_last);
        bit r;
        int n;
        valid = 1'b1;
        data  = c;
        last  = is_last;
        n     = 0;
        forever begin
            @(negedge clk);
            r = src0.in_ready;
            @(posedge clk); #1;
            if (r) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("[TB] FAIL handshake_timeout: byte 0x%h, got in_ready=0, required 1", c);
                break;
            end
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic run_stream(input string s, input int gap);
        for (int k = 0; k < 3; k++) begin
            predict(k, s);
            run_cnt[k] = 0;
        end
        gap_nrdy = 0;
        pulse_start();
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], i == s.len() - 1);
            if (i != s.len() - 1) begin
                repeat (gap) begin
                    @(negedge clk);
                    if (src0.in_ready !== 1'b1) gap_nrdy++;
                    @(posedge clk); #1;
                end
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({src0.in_ready, we[0], rn[0], bs[0], dn[0], er[0]} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got rdy/we/run/busy/done/err=%b, required 000000",
                     {src0.in_ready, we[0], rn[0], bs[0], dn[0], er[0]});
        end
        checks++;
        if ({addr[0], wd[0], len[0], ec[0]} !== 21'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: got addr=%0d op=%b len=%0d code=%b, required all 0",
                     addr[0], wd[0], len[0], ec[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_stream("+>[;<]", 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dn[k] !== 1'b1 || er[k] !== 1'b0 || bs[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_status dut%0d: got done=%b err=%b busy=%b, required 1 0 0",
                         k, dn[k], er[k], bs[k]);
            end
            checks++;
            if (len[k] !== 8'd6) begin
                errors++;
                $display("[TB] FAIL basic_len dut%0d: got %0d, required 6", k, len[k]);
            end
            checks++;
            if (run_cnt[k] !== 1) begin
                errors++;
                $display("[TB] FAIL basic_run dut%0d: got %0d run cycles, required 1", k, run_cnt[k]);
            end
            checks++;
            if (exp_q[k].size() !== 0) begin
                errors++;
                $display("[TB] FAIL basic_writes dut%0d: got %0d writes missing, required 0", k, exp_q[k].size());
            end
        end
    endtask

    task automatic test_comments();
        run_stream("a+ b\n,", 1);
        checks++;
        if (gap_nrdy !== 0) begin
            errors++;
            $display("[TB] FAIL comment_ready: got %0d idle cycles with in_ready=0, required 0", gap_nrdy);
        end
        checks++;
        if (len[0] !== 8'd2 || dn[0] !== 1'b1 || run_cnt[0] !== 1) begin
            errors++;
            $display("[TB] FAIL comment_status: got len=%0d done=%b runs=%0d, required 2 1 1",
                     len[0], dn[0], run_cnt[0]);
        end
        checks++;
        if (exp_q[0].size() !== 0) begin
            errors++;
            $display("[TB] FAIL comment_writes: got %0d writes missing, required 0", exp_q[0].size());
        end
    endtask

    task automatic test_underflow();
        run_stream("]+++", 1);
        checks++;
        if (gap_nrdy !== 0) begin
            errors++;
            $display("[TB] FAIL underflow_drain_ready: got %0d cycles with in_ready=0, required 0", gap_nrdy);
        end
        checks++;
        if (er[0] !== 1'b1 || ec[0] !== 2'b01 || dn[0] !== 1'b0 || bs[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underflow_status: got err=%b code=%b done=%b busy=%b, required 1 01 0 0",
                     er[0], ec[0], dn[0], bs[0]);
        end
        checks++;
        if (run_cnt[0] !== 0 || len[0] !== 8'd0) begin
            errors++;
            $display("[TB] FAIL underflow_run: got runs=%0d len=%0d, required 0 0", run_cnt[0], len[0]);
        end
    endtask

    task automatic test_unclosed();
        run_stream("[[+]", 0);
        checks++;
        if (er[0] !== 1'b1 || ec[0] !== 2'b00 || run_cnt[0] !== 0) begin
            errors++;
            $display("[TB] FAIL unclosed_status: got err=%b code=%b runs=%0d, required 1 00 0",
                     er[0], ec[0], run_cnt[0]);
        end
        checks++;
        if (exp_q[0].size() !== 0 || len[0] !== 8'd4) begin
            errors++;
            $display("[TB] FAIL unclosed_writes: got %0d missing len=%0d, required 0 missing len=4",
                     exp_q[0].size(), len[0]);
        end
    endtask

    task automatic test_depth();
        run_stream("[[[[", 0);
        checks++;
        if (er[1] !== 1'b1 || ec[1] !== 2'b10 || len[1] !== 8'd3 || run_cnt[1] !== 0) begin
            errors++;
            $display("[TB] FAIL depth_limit: got err=%b code=%b len=%0d runs=%0d, required 1 10 3 0",
                     er[1], ec[1], len[1], run_cnt[1]);
        end
        checks++;
        if (er[0] !== 1'b1 || ec[0] !== 2'b00 || len[0] !== 8'd4) begin
            errors++;
            $display("[TB] FAIL depth_default: got err=%b code=%b len=%0d, required 1 00 4",
                     er[0], ec[0], len[0]);
        end
        checks++;
        if (exp_q[1].size() !== 0 || exp_q[0].size() !== 0) begin
            errors++;
            $display("[TB] FAIL depth_writes: got missing dut1=%0d dut0=%0d, required 0 0",
                     exp_q[1].size(), exp_q[0].size());
        end
    endtask

    task automatic test_length();
        run_stream("++++++++", 0);
        checks++;
        if (er[2] !== 1'b1 || ec[2] !== 2'b11 || len[2] !== 8'd7 || run_cnt[2] !== 0) begin
            errors++;
            $display("[TB] FAIL length_limit: got err=%b code=%b len=%0d runs=%0d, required 1 11 7 0",
                     er[2], ec[2], len[2], run_cnt[2]);
        end
        checks++;
        if (dn[0] !== 1'b1 || len[0] !== 8'd8 || run_cnt[0] !== 1) begin
            errors++;
            $display("[TB] FAIL length_default: got done=%b len=%0d runs=%0d, required 1 8 1",
                     dn[0], len[0], run_cnt[0]);
        end
        checks++;
        if (exp_q[2].size() !== 0) begin
            errors++;
            $display("[TB] FAIL length_writes: got %0d missing, required 0", exp_q[2].size());
        end
    endtask

    task automatic test_empty();
        run_stream("x", 0);
        checks++;
        if (len[0] !== 8'd0 || dn[0] !== 1'b1 || run_cnt[0] !== 1 || exp_q[0].size() !== 0) begin
            errors++;
            $display("[TB] FAIL empty: got len=%0d done=%b runs=%0d missing=%0d, required 0 1 1 0",
                     len[0], dn[0], run_cnt[0], exp_q[0].size());
        end
    endtask

    task automatic test_idle_valid();
        valid = 1'b1;
        data  = 8'h2B;
        last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (src0.in_ready !== 1'b0 || dn[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL idle_valid: got in_ready=%b done=%b, required 0 1", src0.in_ready, dn[0]);
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic test_reset_restart();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 3; a++) exp_q[k].push_back({a[7:0], 3'b001});
            run_cnt[k] = 0;
        end
        pulse_start();
        send_byte(8'h2B, 1'b0);
        start = 1'b1;
        send_byte(8'h2B, 1'b0);
        start = 1'b0;
        send_byte(8'h2B, 1'b0);
        #6;
        checks++;
        if (bs[0] !== 1'b1 || src0.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_busy: got busy=%b in_ready=%b, required 1 1", bs[0], src0.in_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({src0.in_ready, we[0], rn[0], bs[0], dn[0], er[0], addr[0], wd[0], len[0], ec[0]} !== 27'b0) begin
            errors++;
            $display("[TB] FAIL restart_async_reset: got rdy=%b we=%b busy=%b addr=%0d len=%0d, required all 0",
                     src0.in_ready, we[0], bs[0], addr[0], len[0]);
        end
        checks++;
        if (exp_q[0].size() !== 0 || run_cnt[0] !== 0) begin
            errors++;
            $display("[TB] FAIL restart_partial: got missing=%0d runs=%0d, required 0 0",
                     exp_q[0].size(), run_cnt[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        run_stream("+>", 0);
        checks++;
        if (dn[0] !== 1'b1 || len[0] !== 8'd2 || run_cnt[0] !== 1 || exp_q[0].size() !== 0) begin
            errors++;
            $display("[TB] FAIL restart_reload: got done=%b len=%0d runs=%0d missing=%0d, required 1 2 1 0",
                     dn[0], len[0], run_cnt[0], exp_q[0].size());
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) run_cnt[k] = 0;
        $display("[TB] starting bf_prog_loader bench");
        test_reset();
        test_basic();
        test_comments();
        test_underflow();
        test_unclosed();
        test_depth();
        test_length();
        test_empty();
        test_idle_valid();
        test_reset_restart();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bf_prog_loader.md
Name: bf_prog_loader

Overview:
Program-load sequencer for the boolfuck core. Takes an ASCII source stream over a valid/ready handshake and translates Boolfuck characters into 3-bit opcodes. Writes the opcodes into the core's program memory, appends a halt terminator and checks bracket balance and nesting depth. On success it pulses `run`. It replaces manual keypad entry of the program.

Parameters:
C, 8, program address width (program memory depth 2**C)
S, 6, core loop-stack index width; legal nesting depth is 1 .. 2**S-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a load; sampled only in IDLE, DONE or ERR
in_valid  in  1  source byte valid
in_ready  out  1  loader accepts byte (combinational from state)
in_data  in  8  ASCII source byte
in_last  in  1  marks final byte of source
prg_we  out  1  program memory write strobe
prg_addr  out  C  program memory write address
prg_wdata  out  3  opcode to write
prg_len  out  C  opcodes written, excluding terminator
run  out  1  one-cycle pulse: program loaded and valid, core may reset and run
busy  out  1  high in LOAD, DRAIN, TERM
done  out  1  high in DONE
err  out  1  high in ERR
err_code  out  2  00 unclosed '[' at end, 01 ']' underflow, 10 nesting too deep, 11 program too long

Behaviour:
- Opcode map:
  - '\0' → 000 (terminator, written only by the loader)
  - '+' → 001
  - '<' → 010
  - '>' → 011
  - ';' → 100
  - ',' → 101
  - '[' → 110
  - ']' → 111
  - All other bytes are comments: accepted and discarded, no write.
- Reset (async, rst_n low):
  - State IDLE.
  - in_ready, prg_we, run, busy, done and err are 0.
  - prg_addr, prg_wdata, prg_len and err_code are 0.
  - Internal address counter and depth counter (S bits) are 0.
- States: IDLE, LOAD, DRAIN, TERM, DONE, ERR.
- IDLE/DONE/ERR + start → LOAD:
  - Clear the address counter, depth counter, prg_len and err_code.
  - done and err drop the same edge.
  - start is ignored while busy.
- LOAD:
  - in_ready=1. A handshake is in_valid & in_ready.
  - Op byte: prg_we=1 the cycle after the handshake, with prg_addr = current count and prg_wdata = opcode. Then the count and prg_len increment.
  - Registered write: 1-cycle latency, at most one write per cycle, back-to-back bytes supported.
  - '[': depth+1. If depth is already 2**S-1, take error 10 and write nothing.
  - ']': depth-1. If depth is 0, take error 01 and write nothing.
  - Any op byte when the count is 2**C-1 (no room for the terminator): error 11, no write.
  - Error with in_last=0 → DRAIN. Error with in_last=1 → ERR. err_code latches the first error only.
  - Valid byte with in_last=1 → TERM.
- DRAIN:
  - in_ready=1.
  - Discard bytes until a handshake with in_last=1, then → ERR.
  - No writes.
- TERM:
  - One cycle, in_ready=0.
  - Write 000 at the address count. prg_len is not incremented.
  - Depth 0 → DONE, with run=1 for exactly the first cycle of DONE.
  - Depth ≠ 0 → ERR with code 00.
- A comment byte with in_last → TERM still writes the terminator.
- An empty stream (a single comment byte with in_last) gives prg_len=0, a terminator at address 0, and then run.
- in_valid while not in LOAD/DRAIN: in_ready=0, byte stays with the source.
- rst_n asserted mid-LOAD aborts immediately:
  - No further writes.
  - The partially written program memory contents are undefined to the consumer.
  - run is never issued.
- Counter arithmetic is C bits. The address never wraps, because the overflow check precedes the increment.

Test Plan:
- Source "+>[;<]" with in_last on ']':
  - Writes 001,011,110,100,010,111 at addresses 0-5, then 000 at address 6.
  - prg_len=6, run pulses once, done=1.
- Source "a+ b\n," with in_valid toggled every other cycle:
  - Writes only 001@0 and 101@1, then terminator @2; prg_len=2.
  - in_ready holds 1 throughout LOAD.
- Source "]+++" (last on the final '+'): err_code=01, no prg_we after the error, in_ready stays high until in_last, then err=1 and no run.
- Source "[[+]": TERM writes 000@4, then err=1 with err_code=00, no run.
- With S=2, source "[[[[" (fourth '[' exceeds depth 3): err_code=10 and exactly 3 writes.
- With C=3, an 8-op source: ops at 0-6, error 11 on the 8th op byte.
- Reset and restart:
  - rst_n pulled low during LOAD after 3 writes: all outputs 0 asynchronously, state IDLE.
  - A new start then reloads from address 0.
  - start pulsed during LOAD is ignored.
